// File: rtl/counter_ctrl_pkg.sv
// Shared types and encodings for the counter sequencing controller.
// State names, direction and mode codes used by the controller and its engine.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command and status bundle between a run requester and counter_ctrl.
// The requester owns the commands and config; the controller owns the status.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);

    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, pause, dir, mode, load_val,
        input  count, busy, tc, done
    );

    modport slave (
        input  start, stop, pause, dir, mode, load_val,
        output count, busy, tc, done
    );

endinterface

// File: rtl/count_core.sv
// Loadable up/down count register stepped by the sequencing controller.
// A load always wins over a step in the same cycle.
module count_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (dir == DIR_UP) ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run sequencer for a count engine: start/stop/pause, per-run config,
// terminal-count strobe and one-shot completion flag.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    counter_ctrl_if.slave bus
);

    state_t           state;
    logic             dir_q;
    logic             mode_q;
    logic [WIDTH-1:0] val_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] sv;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] new_sv;
    logic [WIDTH-1:0] core_val;
    logic             idle_or_done;
    logic             go;
    logic             live;
    logic             at_term;
    logic             tc;
    logic             core_load;
    logic             core_en;

    assign sv     = (dir_q == DIR_DOWN) ? val_q : '0;
    assign term   = (dir_q == DIR_DOWN) ? '0 : val_q;
    assign new_sv = (bus.dir == DIR_DOWN) ? bus.load_val : '0;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign go           = idle_or_done && bus.start && !bus.stop;
    assign live         = (state == ST_RUN) && !bus.stop && !bus.pause;
    assign at_term      = (bus.count == term);
    assign tc           = live && at_term;

    // A fresh start seeds from the incoming config, a reload from the latched one
    assign core_load = go || (tc && (mode_q == MODE_RELOAD));
    assign core_val  = go ? new_sv : sv;
    assign core_en   = live && !at_term;

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .en       (core_en),
        .dir      (dir_q),
        .q        (bus.count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
            val_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                    end else if (bus.start) begin
                        state  <= ST_RUN;
                        dir_q  <= bus.dir;
                        mode_q <= bus.mode;
                        val_q  <= bus.load_val;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.pause) begin
                        state <= ST_HOLD;
                    end else if (at_term && (mode_q == MODE_ONESHOT)) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (!bus.pause) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tc   = tc;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with hand-computed expectations.
module tb_counter_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   c0;

    counter_ctrl_if #(.WIDTH(4)) bus ();

    counter_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input logic d, input logic m, input logic [3:0] v);
        bus.start    = 1'b1;
        bus.dir      = d;
        bus.mode     = m;
        bus.load_val = v;
        tick();
        bus.start = 1'b0;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.pause    = 1'b0;
        bus.dir      = 1'b0;
        bus.mode     = 1'b0;
        bus.load_val = 4'd0;

        #3;
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_tc", bus.tc, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", bus.busy, 0);
        check("idle_count", bus.count, 0);

        // asynchronous reset in the middle of an up run
        go(1'b0, 1'b0, 4'd9);
        repeat (4) tick();
        check("pre_rst_count", bus.count, 4);
        check("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_tc", bus.tc, 0);
        #2 rst = 1'b1;
        tick();
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_count", bus.count, 0);
        tick();
        check("post_rst_hold", bus.count, 0);

        // up one-shot to 5
        go(1'b0, 1'b0, 4'd5);
        for (int i = 0; i <= 5; i++) begin
            check("up_count", bus.count, i);
            check("up_tc", bus.tc, (i == 5) ? 1 : 0);
            check("up_busy", bus.busy, 1);
            tick();
        end
        check("up_done", bus.done, 1);
        check("up_busy_end", bus.busy, 0);
        check("up_count_end", bus.count, 5);
        check("up_tc_end", bus.tc, 0);
        tick();
        check("up_count_stay", bus.count, 5);
        check("up_done_stay", bus.done, 1);

        // down auto-reload from 3
        go(1'b1, 1'b1, 4'd3);
        for (int i = 0; i < 12; i++) begin
            check("rl_count", bus.count, 3 - (i % 4));
            check("rl_tc", bus.tc, ((i % 4) == 3) ? 1 : 0);
            check("rl_busy", bus.busy, 1);
            check("rl_done", bus.done, 0);
            tick();
        end
        bus.stop = 1'b1;
        #1;
        check("rl_stop_tc", bus.tc, 0);
        tick();
        bus.stop = 1'b0;
        check("rl_stop_busy", bus.busy, 0);
        check("rl_stop_count", bus.count, 3);
        check("rl_stop_done", bus.done, 0);

        // pause for three cycles at count 2
        go(1'b0, 1'b0, 4'd7);
        c0 = cyc;
        tick();
        tick();
        bus.pause = 1'b1;
        #1;
        check("pz_count0", bus.count, 2);
        check("pz_tc0", bus.tc, 0);
        tick();
        check("pz_count1", bus.count, 2);
        check("pz_tc1", bus.tc, 0);
        check("pz_busy1", bus.busy, 1);
        tick();
        check("pz_count2", bus.count, 2);
        check("pz_tc2", bus.tc, 0);
        tick();
        bus.pause = 1'b0;
        #1;
        check("pz_hold_count", bus.count, 2);
        check("pz_hold_tc", bus.tc, 0);
        tick();
        check("pz_resume_count", bus.count, 2);
        tick();
        for (int v = 3; v <= 7; v++) begin
            check("pz_count", bus.count, v);
            check("pz_tc", bus.tc, (v == 7) ? 1 : 0);
            if (v == 7) check("pz_tc_cycle", cyc - c0, 11);
            tick();
        end
        check("pz_done", bus.done, 1);

        // start ignored mid-run, then stop
        go(1'b0, 1'b0, 4'd10);
        check("st_done_clr", bus.done, 0);
        repeat (3) tick();
        check("st_count3", bus.count, 3);
        bus.start    = 1'b1;
        bus.dir      = 1'b1;
        bus.load_val = 4'd0;
        tick();
        bus.start = 1'b0;
        check("st_ign_count", bus.count, 4);
        check("st_ign_busy", bus.busy, 1);
        bus.stop = 1'b1;
        #1;
        check("st_stop_tc", bus.tc, 0);
        tick();
        bus.stop = 1'b0;
        check("st_count_hold", bus.count, 4);
        check("st_busy", bus.busy, 0);
        check("st_done", bus.done, 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy", bus.busy, 0);
        check("ss_count", bus.count, 4);
        tick();
        check("ss_count2", bus.count, 4);
        check("ss_busy2", bus.busy, 0);

        // load_val of zero terminates on the first run cycle
        go(1'b0, 1'b0, 4'd0);
        check("z_count", bus.count, 0);
        check("z_tc", bus.tc, 1);
        check("z_busy", bus.busy, 1);
        tick();
        check("z_done", bus.done, 1);
        check("z_busy_end", bus.busy, 0);
        check("z_tc_end", bus.tc, 0);

        // full-range up run must stop at 15
        go(1'b0, 1'b0, 4'd15);
        repeat (15) tick();
        check("max_count", bus.count, 15);
        check("max_tc", bus.tc, 1);
        tick();
        check("max_done", bus.done, 1);
        check("max_hold", bus.count, 15);
        tick();
        check("max_nowrap", bus.count, 15);

        // restart from DONE counting down from 2
        go(1'b1, 1'b0, 4'd2);
        check("dn_done_clr", bus.done, 0);
        check("dn_busy", bus.busy, 1);
        check("dn_count2", bus.count, 2);
        check("dn_tc2", bus.tc, 0);
        tick();
        check("dn_count1", bus.count, 1);
        tick();
        check("dn_count0", bus.count, 0);
        check("dn_tc0", bus.tc, 1);
        tick();
        check("dn_done", bus.done, 1);
        check("dn_end", bus.count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Synchronous sequencing controller for a WIDTH-bit count engine, the next step past the ripple counters in this codebase.
- Accepts a start/stop/pause command interface, latches a per-run configuration (direction, mode, terminal value), and steps the engine one count per clock.
- Flags the terminal count and run completion for downstream timing logic.
- Fully synchronous; no derived clocks.

Parameters:
- WIDTH, 4, bit width of count, load_val and the internal engine.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- start  input  1  begin a run; sampled only in IDLE or DONE.
- stop  input  1  abort the run; return to IDLE.
- pause  input  1  level; freezes counting while high in RUN/HOLD.
- dir  input  1  0 = up, 1 = down; latched at start.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
- load_val  input  WIDTH  terminal value (up) or start value (down); latched at start.
- count  output  WIDTH  current engine value, registered.
- busy  output  1  high in RUN or HOLD, registered.
- tc  output  1  terminal-count strobe (see below).
- done  output  1  high in DONE (one-shot complete), registered.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, count=0, busy=0, done=0, cfg registers (dir_q, mode_q, val_q)=0. tc=0 while in reset.
- States: IDLE, RUN, HOLD, DONE. 2-bit state register.
- Start value: sv = (dir_q ? val_q : 0). Terminal value: term = (dir_q ? 0 : val_q).
- IDLE or DONE with start=1 and stop=0:
  - latch dir, mode and load_val into the cfg registers;
  - count <= sv computed from the new inputs;
  - next state RUN; busy=1 and done=0 from the next cycle.
- RUN, per cycle, priority stop > pause > terminal > step:
  - stop=1: go to IDLE, count holds, busy<=0.
  - pause=1: go to HOLD, count holds.
  - count==term: tc=1 this cycle. If mode_q=0, go to DONE with count held at term, busy<=0, done<=1. If mode_q=1, count <= sv and stay in RUN.
  - otherwise: count <= count+1 (up) or count-1 (down).
- HOLD:
  - stop=1: go to IDLE.
  - pause=0: go to RUN, with no step in the resume cycle.
  - count is frozen; tc=0.
- DONE: done=1, count holds term. Entry from DONE is via start or stop only; stop goes to IDLE and clears done.
- tc is Mealy: tc = (state==RUN) & (count==term) & ~stop & ~pause. It is high for exactly one cycle per terminal reach; in auto-reload mode it pulses every val_q+1 cycles.
- Count latency: count first shows sv in the cycle after start is sampled. One step per cycle thereafter, so a full run spans val_q+1 RUN cycles.
- No wrap-around: count never passes term, so WIDTH overflow cannot occur.
- load_val=0: sv==term, so tc asserts on the first RUN cycle.
- start in RUN or HOLD is ignored. Config inputs are don't-care except at start.
- start and stop together in IDLE or DONE: stop wins, remain in or go to IDLE.
- rst asserted mid-run: immediate return to reset values. No partial tc.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2, ST_DONE=2'd3;
  - DIR_UP=0, DIR_DOWN=1;
  - MODE_ONESHOT=0, MODE_RELOAD=1.
- One sub-module, count_core:
  - WIDTH register with clk, rst, load, load_val, en, dir, output q;
  - load has priority over en.
- counter_ctrl contains the FSM, the cfg latches and the tc/done decode. It drives count_core load/en/dir.

Test Plan:
- Reset: run up with load_val=9, pull rst low at count=4 between clock edges -> count=0, busy=0, done=0, tc=0 immediately; state IDLE after release.
- Up one-shot, load_val=5, start for one cycle -> count 0,1,2,3,4,5 on successive cycles, tc=1 only at 5, then done=1, busy=0, count stays 5.
- Down auto-reload, load_val=3 -> count 3,2,1,0,3,2,1,0..., tc pulses every 4th cycle at count=0, busy stays 1, done stays 0.
- Pause/resume, up, load_val=7 -> pause high for 3 cycles at count=2 gives count=2 and tc=0 throughout; after release count goes 3,4,...; terminal tc is delayed by exactly 4 cycles (3 paused plus 1 resume).
- Stop and ignored start, up, load_val=10 -> start re-pulsed at count=3 has no effect; stop at count=4 gives IDLE, count holds 4, busy=0, no tc; start+stop together in IDLE stays in IDLE.
- Boundaries, WIDTH=4:
  - load_val=0 up one-shot -> tc on first RUN cycle, then done.
  - load_val=15 up -> reaches 15 with tc and never wraps to 0.
  - start from DONE with dir=1, load_val=2 -> 2,1,0 with done cleared.
